// File: rtl/or_plane_core.sv
// Programmable registered logic plane: each output channel reduces a masked subset of the inputs (OR/AND/XOR/NOR).
// Optional feature macro: OR_PLANE_STICKY_EN (adds sticky_clr and makes outputs sticky).
module or_plane_core #(
  parameter int unsigned W_IN  = 8,
  parameter int unsigned N_OUT = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [W_IN-1:0]   ui_in,
  output logic [N_OUT-1:0]  uo_out,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  cfg_sel,
  input  logic [W_IN-1:0]   cfg_mask,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_commit,
  output logic              cfg_err
`ifdef OR_PLANE_STICKY_EN
  ,
  input  logic              sticky_clr
`endif
);

  localparam int unsigned SEL_W1 = SEL_W + 1;

  localparam logic [1:0] MODE_OR  = 2'b00;
  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_WR    = 2'b01,
    S_CM    = 2'b10,
    S_WR_CM = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic              accept_c;
  logic              shadow_we_c;
  logic              commit_we_c;
  logic              sel_ok_c;

  logic [SEL_W-1:0]  cap_sel;
  logic [W_IN-1:0]   cap_mask;
  logic [1:0]        cap_mode;

  logic [W_IN-1:0]   sh_mask  [N_OUT];
  logic [1:0]        sh_mode  [N_OUT];
  logic [W_IN-1:0]   act_mask [N_OUT];
  logic [1:0]        act_mode [N_OUT];

  logic [W_IN-1:0]   in_q;
  logic [N_OUT-1:0]  hit_c;

  // State register; cfg_ready registered from the next state so it equals (state == IDLE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nxt;
      cfg_ready <= (state_nxt == S_IDLE);
    end
  end

  // Config FSM next-state and strobes; commit/valid only sampled in IDLE.
  always_comb begin
    state_nxt   = state;
    accept_c    = 1'b0;
    shadow_we_c = 1'b0;
    commit_we_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_valid && cfg_commit) begin
          accept_c  = 1'b1;
          state_nxt = S_WR_CM;
        end else if (cfg_valid) begin
          accept_c  = 1'b1;
          state_nxt = S_WR;
        end else if (cfg_commit) begin
          state_nxt = S_CM;
        end
      end
      S_WR: begin
        shadow_we_c = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_WR_CM: begin
        shadow_we_c = 1'b1;
        state_nxt   = S_CM;
      end
      S_CM: begin
        commit_we_c = 1'b1;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Extra select bit keeps the range check correct when N_OUT == 2**SEL_W.
  assign sel_ok_c = ({1'b0, cap_sel} < SEL_W1'(N_OUT));

  // Write request captured on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_sel  <= '0;
      cap_mask <= '0;
      cap_mode <= MODE_OR;
    end else if (accept_c) begin
      cap_sel  <= cfg_sel;
      cap_mask <= cfg_mask;
      cap_mode <= cfg_mode;
    end
  end

  // Shadow and active configuration banks; commit copies every channel on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < int'(N_OUT); c++) begin
        sh_mask[c]  <= '0;
        sh_mode[c]  <= MODE_OR;
        act_mask[c] <= '0;
        act_mode[c] <= MODE_OR;
      end
      cfg_err <= 1'b0;
    end else begin
      if (shadow_we_c) begin
        for (int c = 0; c < int'(N_OUT); c++) begin
          if (sel_ok_c && (cap_sel == SEL_W'(c))) begin
            sh_mask[c] <= cap_mask;
            sh_mode[c] <= cap_mode;
          end
        end
        if (!sel_ok_c) begin
          cfg_err <= 1'b1;
        end
      end
      if (commit_we_c) begin
        for (int c = 0; c < int'(N_OUT); c++) begin
          act_mask[c] <= sh_mask[c];
          act_mode[c] <= sh_mode[c];
        end
      end
    end
  end

  // Per-channel reduction; an empty mask yields 0 in every mode.
  always_comb begin
    hit_c = '0;
    for (int c = 0; c < int'(N_OUT); c++) begin
      case (act_mode[c])
        MODE_OR:  hit_c[c] = |(in_q & act_mask[c]);
        MODE_AND: hit_c[c] = (|act_mask[c]) && ((in_q & act_mask[c]) == act_mask[c]);
        MODE_XOR: hit_c[c] = ^(in_q & act_mask[c]);
        MODE_NOR: hit_c[c] = (|act_mask[c]) && !(|(in_q & act_mask[c]));
        default:  hit_c[c] = 1'b0;
      endcase
    end
  end

  // Two-stage data path gated by ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q   <= '0;
      uo_out <= '0;
    end else begin
      if (ena) begin
        in_q <= ui_in;
      end
`ifdef OR_PLANE_STICKY_EN
      if (sticky_clr) begin
        uo_out <= '0;
      end else if (ena) begin
        uo_out <= uo_out | hit_c;
      end
`else
      if (ena) begin
        uo_out <= hit_c;
      end
`endif
    end
  end

endmodule
